// File: rtl/game_over_index_gen.sv
// Game-over overlay index generator: scan position -> sprite ROM address -> aligned palette index,
// with a per-frame drop/hold animation. Define GAME_OVER_BLINK_EN to add the BLINK phase after HOLD.
module game_over_index_gen #(
  parameter int          IMG_W       = 160,
  parameter int          IMG_H       = 120,
  parameter int          X0          = 160,
  parameter int          Y0          = 120,
  parameter int          DROP_STEP   = 8,
  parameter int          HOLD_FRAMES = 60,
  parameter int          BLINK_HALF  = 16,
  parameter logic [3:0]  TRANSP_IDX  = 4'h6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        show,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [14:0] rom_addr,
  input  logic [3:0]  rom_q,
  output logic [3:0]  index,
  output logic        overlay_en
);

  localparam logic signed [10:0] X0_S    = 11'(X0);
  localparam logic signed [10:0] Y0_S    = 11'(Y0);
  localparam logic signed [10:0] OVL_W_S = 11'(2 * IMG_W);
  localparam logic signed [10:0] OVL_H_S = 11'(2 * IMG_H);
  localparam logic [9:0]         OVL_H_U = 10'(2 * IMG_H);
  localparam logic [9:0]         STEP_U  = 10'(DROP_STEP);

  if (HOLD_FRAMES < 1 || BLINK_HALF < 1 || DROP_STEP < 1) begin : g_param_check
    $error("game_over_index_gen: HOLD_FRAMES, BLINK_HALF and DROP_STEP must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_HOLD, S_BLINK} state_t;

  state_t     r_state;
  logic [9:0] r_y_off;
  logic       r_vis;
  logic       r_hit_d1;
  logic       r_hit_d2;

`ifdef GAME_OVER_BLINK_EN
  localparam int CNT_MAX = (HOLD_FRAMES > BLINK_HALF) ? HOLD_FRAMES : BLINK_HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  logic [CW-1:0] r_cnt;
`endif

  // Geometry in signed 11-bit so positions left of / above the overlay go negative.
  logic signed [10:0] w_top;
  logic signed [10:0] w_sx;
  logic signed [10:0] w_sy;
  logic               w_hit;
  logic [14:0]        w_row;
  logic [14:0]        w_col;
  logic [14:0]        w_addr;
  logic               w_opaque;

  assign w_top  = Y0_S - $signed({1'b0, r_y_off});
  assign w_sy   = $signed({1'b0, DrawY}) - w_top;
  assign w_sx   = $signed({1'b0, DrawX}) - X0_S;
  assign w_hit  = !w_sx[10] && (w_sx < OVL_W_S) && !w_sy[10] && (w_sy < OVL_H_S);
  assign w_row  = 15'(w_sy[9:1]);
  assign w_col  = 15'(w_sx[9:1]);
  // row*160 as two shifts; the 2x scale is the drop of bit 0 above
  assign w_addr = (w_row << 7) + (w_row << 5) + w_col;

  assign w_opaque = r_hit_d2 && r_vis && (r_state != S_IDLE) && (rom_q != TRANSP_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr   <= '0;
      r_hit_d1   <= 1'b0;
      r_hit_d2   <= 1'b0;
      index      <= '0;
      overlay_en <= 1'b0;
    end else begin
      rom_addr   <= w_hit ? w_addr : 15'd0;
      r_hit_d1   <= w_hit;
      r_hit_d2   <= r_hit_d1;
      overlay_en <= w_opaque;
      index      <= w_opaque ? rom_q : 4'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_y_off <= OVL_H_U;
      r_vis   <= 1'b0;
`ifdef GAME_OVER_BLINK_EN
      r_cnt   <= '0;
`endif
    end else if (frame_start) begin
      if (!show) begin
        r_state <= S_IDLE;
        r_vis   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_DROP;
            r_y_off <= OVL_H_U;
            r_vis   <= 1'b1;
          end
          S_DROP: begin
            if (r_y_off <= STEP_U) begin
              r_y_off <= '0;
              r_state <= S_HOLD;
`ifdef GAME_OVER_BLINK_EN
              r_cnt   <= '0;
`endif
            end else begin
              r_y_off <= r_y_off - STEP_U;
            end
          end
`ifdef GAME_OVER_BLINK_EN
          S_HOLD: begin
            if (r_cnt == CW'(HOLD_FRAMES - 1)) begin
              r_state <= S_BLINK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_BLINK: begin
            if (r_cnt == CW'(BLINK_HALF - 1)) begin
              r_cnt <= '0;
              r_vis <= ~r_vis;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`else
          S_HOLD: r_state <= S_HOLD;
`endif
          default: r_state <= S_HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_over_index_gen.sv
// Randomized bench for game_over_index_gen: a frame-level animation model plus a pixel-level
// geometry model predict rom_addr, index and overlay_en for each scanned pixel.
module tb_game_over_index_gen;

  localparam int ROM_DEPTH = 19200;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        show;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  index;
  logic        overlay_en;

  always #5 Clk = ~Clk;

  game_over_index_gen dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .show       (show),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .index      (index),
    .overlay_en (overlay_en)
  );

  // Sprite BRAM with one-cycle registered read.
  logic [3:0] rom_mem [0:ROM_DEPTH-1];
  always_ff @(posedge Clk) begin
    if (int'(rom_addr) < ROM_DEPTH) rom_q <= rom_mem[rom_addr];
    else                            rom_q <= 4'd0;
  end

  int errors = 0;
  int checks = 0;

  // Reference animation state: mode 0=idle 1=drop 2=hold 3=blink.
  int m_mode;
  int m_yoff;
  int m_vis;
  int m_hold_n;
  int m_blink_n;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_yoff = 240; m_vis = 0; m_hold_n = 0; m_blink_n = 0;
  endtask

  task automatic model_frame(input logic shw);
    if (!shw) begin
      m_mode = 0;
      m_vis  = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_yoff = 240; m_vis = 1; end
        1: begin
          m_yoff = (m_yoff > 8) ? m_yoff - 8 : 0;
          if (m_yoff == 0) begin m_mode = 2; m_hold_n = 0; end
        end
        2: begin
`ifdef GAME_OVER_BLINK_EN
          m_hold_n++;
          if (m_hold_n == 60) begin m_mode = 3; m_blink_n = 0; end
`endif
        end
        default: begin
          m_blink_n++;
          m_vis = ((m_blink_n / 16) % 2 == 0) ? 1 : 0;
        end
      endcase
    end
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    model_frame(show);
  endtask

  task automatic pixel(input int x, input int y, input string tag);
    int sx, sy, addr, q, en, idx;
    bit hit;
    sy   = y - (120 - m_yoff);
    sx   = x - 160;
    hit  = (sx >= 0) && (sx < 320) && (sy >= 0) && (sy < 240);
    addr = hit ? (sy / 2) * 160 + (sx / 2) : 0;
    q    = int'(rom_mem[addr]);
    en   = (hit && m_vis != 0 && m_mode != 0 && q != 6) ? 1 : 0;
    idx  = (en != 0) ? q : 0;
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk); #1;
    check_val({tag, ".rom_addr"}, int'(rom_addr), addr);
    @(posedge Clk);
    @(posedge Clk); #1;
    check_val({tag, ".index"}, int'(index), idx);
    check_val({tag, ".overlay_en"}, int'(overlay_en), en);
    $display("pix %-10s x=%0d y=%0d mode=%0d yoff=%0d addr=%0d idx=%0d en=%0d",
             tag, x, y, m_mode, m_yoff, rom_addr, index, overlay_en);
  endtask

  task automatic rand_pixel(input string tag);
    int x, y, top;
    top = 120 - m_yoff;
    if ($urandom_range(0, 1) == 0) begin
      x = int'($urandom_range(0, 799));
      y = int'($urandom_range(0, 524));
    end else begin
      x = int'($urandom_range(140, 500));
      y = top - 20 + int'($urandom_range(0, 280));
      if (y < 0)   y = 0;
      if (y > 524) y = 524;
    end
    pixel(x, y, tag);
  endtask

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[0]     = 4'h2;
    rom_mem[1]     = 4'h6;
    rom_mem[19199] = 4'hA;

    Reset = 1'b1; show = 1'b1; frame_start = 1'b0; DrawX = '0; DrawY = '0;
    model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    check_val("rst.index", int'(index), 0);
    check_val("rst.overlay_en", int'(overlay_en), 0);
    check_val("rst.rom_addr", int'(rom_addr), 0);
    Reset = 1'b0;

    // Idle: nothing visible, show=0 pulse keeps it idle
    pixel(160, 120, "idle0");
    show = 1'b0;
    frame_pulse();
    for (int i = 0; i < 3; i++) rand_pixel("idle");

    // Enter DROP and descend to y_off=0
    show = 1'b1;
    frame_pulse();
    pixel(160, 0, "drop0");
    rand_pixel("drop0r");
    for (int f = 0; f < 30; f++) begin
      frame_pulse();
      rand_pixel("drop");
      rand_pixel("drop");
    end

    // Corner / boundary pixels in HOLD
    pixel(160, 120, "hold_tl");
    pixel(479, 359, "hold_br");
    pixel(159, 120, "hold_xl");
    pixel(162, 120, "hold_tr");
    pixel(480, 359, "hold_xr");
    pixel(479, 360, "hold_yb");
    pixel(160, 119, "hold_ya");

    // HOLD and (if built in) BLINK animation over 200 frames
    for (int f = 0; f < 200; f++) begin
      frame_pulse();
      pixel(160, 120, "anim_tl");
      rand_pixel("anim");
    end

    // Reset mid-operation with an opaque pixel in flight
    DrawX = 10'd479; DrawY = 10'd359;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    model_reset();
    check_val("mid_rst.index", int'(index), 0);
    check_val("mid_rst.overlay_en", int'(overlay_en), 0);
    check_val("mid_rst.rom_addr", int'(rom_addr), 0);
    Reset = 1'b0;
    pixel(300, 100, "post_rst");

    // Drop halfway, then withdraw show
    show = 1'b1;
    frame_pulse();
    for (int f = 0; f < 15; f++) frame_pulse();
    pixel(160, 0, "half_top");
    pixel(300, 100, "half_mid");
    rand_pixel("half");
    show = 1'b0;
    frame_pulse();
    pixel(300, 100, "abort");
    pixel(160, 0, "abort_top");
    rand_pixel("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
